// File: rtl/branch_ctrl.sv
// Branch resolution controller: waits for operands, latches them for an external
// comparator, resolves the branch outcome. Optional counters under BRANCH_STATS_EN.
module branch_ctrl #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_valid,
  input  logic [2:0]  br_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic        kill,
  input  logic        cmp_eq,
  output logic [31:0] cmp_rs,
  output logic [31:0] cmp_rt,
  output logic        stall,
  output logic        br_done,
  output logic        br_taken,
  output logic        br_timeout,
  output logic [31:0] br_count,
  output logic [31:0] taken_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EVAL} state_e;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLEZ = 3'b010;
  localparam logic [2:0] OP_BGTZ = 3'b011;
  localparam logic [2:0] OP_BLTZ = 3'b100;
  localparam logic [2:0] OP_BGEZ = 3'b101;
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] cmp_rs_q, cmp_rt_q;
  logic [2:0]  op_q;
  logic        timeout_q;
  logic        ops_ready;
  logic        latch;
  logic        taken;

  // Single-operand compares (blez and above) never wait on rt.
  assign ops_ready = rs_ready & (rt_ready | (br_op >= OP_BLEZ));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    latch      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!kill && br_valid) begin
          if (ops_ready) begin
            state_d = S_EVAL;
            latch   = 1'b1;
          end else begin
            state_d    = S_WAIT;
            wait_cnt_d = 4'd0;
          end
        end
      end
      S_WAIT: begin
        if (kill) begin
          state_d = S_IDLE;
        end else if (ops_ready) begin
          state_d = S_EVAL;
          latch   = 1'b1;
        end else if (wait_cnt_q != 4'hF) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_EVAL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (op_q)
      OP_BEQ:  taken = cmp_eq;
      OP_BNE:  taken = !cmp_eq;
      OP_BLEZ: taken = cmp_rs_q[31] | cmp_eq;
      OP_BGTZ: taken = !cmp_rs_q[31] & !cmp_eq;
      OP_BLTZ: taken = cmp_rs_q[31];
      OP_BGEZ: taken = !cmp_rs_q[31];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    br_done  = 1'b0;
    br_taken = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_IDLE:  stall = br_valid & !kill;
        S_WAIT:  stall = !kill;
        S_EVAL: begin
          br_done  = !kill;
          br_taken = !kill & taken;
        end
        default: stall = 1'b0;
      endcase
    end
  end

  // Operand latch; rt is zeroed for compare-against-zero ops so the
  // external comparator's equality result means "rs == 0".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_rs_q <= 32'h0;
      cmp_rt_q <= 32'h0;
      op_q     <= OP_BEQ;
    end else if (latch) begin
      cmp_rs_q <= rs_data;
      cmp_rt_q <= (br_op == OP_BEQ || br_op == OP_BNE) ? rt_data : 32'h0;
      op_q     <= br_op;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timeout_q <= 1'b0;
    else if (state_q == S_WAIT && wait_cnt_q == WAIT_LIMIT && !ops_ready)
      timeout_q <= 1'b1;
  end

  assign cmp_rs     = cmp_rs_q;
  assign cmp_rt     = cmp_rt_q;
  assign br_timeout = timeout_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q, taken_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count_q    <= 32'h0;
      taken_count_q <= 32'h0;
    end else if (br_done) begin
      br_count_q <= br_count_q + 32'd1;
      if (br_taken) taken_count_q <= taken_count_q + 32'd1;
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`else
  assign br_count    = 32'h0;
  assign taken_count = 32'h0;
`endif

endmodule
